// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared constants and state encoding for the gate truth checker
package gate_chk_pkg;

   localparam int NUM_GATES = 6;

   localparam int IDX_AND  = 0;
   localparam int IDX_OR   = 1;
   localparam int IDX_NOT  = 2;
   localparam int IDX_NAND = 3;
   localparam int IDX_NOR  = 4;
   localparam int IDX_XOR  = 5;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/gate_expect.sv
// rtl/gate_expect.sv - combinational golden outputs of the basic gate library for one input pair
module gate_expect
   import gate_chk_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   output logic [NUM_GATES-1:0] exp
);

   // NOT is driven from a only; b does not affect it
   always_comb begin
      exp           = '0;
      exp[IDX_AND]  = a & b;
      exp[IDX_OR]   = a | b;
      exp[IDX_NOT]  = ~a;
      exp[IDX_NAND] = ~(a & b);
      exp[IDX_NOR]  = ~(a | b);
      exp[IDX_XOR]  = a ^ b;
   end

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - sweeps a/b through all four vectors and scores the gate outputs
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_GATES-1:0] dut_y,
   output logic                 a,
   output logic                 b,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [NUM_GATES-1:0] fail_mask,
   output logic                 first_fail_vld,
   output logic [1:0]           first_fail_vec
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t               state;
   state_t               state_next;
   logic [1:0]           vec;
   logic [3:0]           settle_cnt;
   logic [NUM_GATES-1:0] exp;
   logic [NUM_GATES-1:0] mism;
   logic [NUM_GATES-1:0] mask_next;

   gate_expect u_expect (
      .a   (a),
      .b   (b),
      .exp (exp)
   );

   always_comb begin
      mism      = dut_y ^ exp;
      mask_next = fail_mask | mism;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SETTLE;
         SETTLE:  if (settle_cnt == 4'd0) state_next = SAMPLE;
         SAMPLE:  state_next = (vec == 2'd3) ? DONE : SETTLE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // pass is computed from mask_next so the final vector's mismatches count
   always_ff @(posedge clk) begin
      if (rst) begin
         a              <= 1'b0;
         b              <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_mask      <= '0;
         first_fail_vld <= 1'b0;
         first_fail_vec <= 2'd0;
         vec            <= 2'd0;
         settle_cnt     <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec            <= 2'd0;
                  a              <= 1'b0;
                  b              <= 1'b0;
                  settle_cnt     <= SETTLE_LOAD;
                  fail_mask      <= '0;
                  first_fail_vld <= 1'b0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
               end
            end
            SETTLE: begin
               if (settle_cnt != 4'd0) begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            SAMPLE: begin
               fail_mask <= mask_next;
               if ((mism != '0) && !first_fail_vld) begin
                  first_fail_vld <= 1'b1;
                  first_fail_vec <= vec;
               end
               if (vec == 2'd3) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  pass <= (mask_next == '0);
               end else begin
                  vec        <= vec + 2'd1;
                  {a, b}     <= vec + 2'd1;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            DONE: begin
               done <= 1'b0;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Self-checking sweep stage around the basic two-input gate library (AND, OR, NOT, NAND, NOR, XOR). It sits directly upstream and downstream of the gates:
- Upstream: drives the shared inputs a and b through all four input combinations.
- Downstream: samples all six gate outputs after a programmable settle time and compares them against an internal golden truth table.
- Reports pass/fail, a per-gate failure mask and the first failing input vector.

Parameters:
SETTLE_CYCLES, 2, cycles a/b are held stable before sampling; legal range 1..15; width of settle counter = 4 bits.

Ports:
clk  in  1  single clock, all logic rising-edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a sweep; ignored unless in IDLE.
dut_y  in  6  gate outputs: [0]AND [1]OR [2]NOT [3]NAND [4]NOR [5]XOR. NOT is fed from a.
a  out  1  registered stimulus to all gates.
b  out  1  registered stimulus to two-input gates.
busy  out  1  high from the cycle after start is accepted until DONE is entered.
done  out  1  one-cycle pulse at end of sweep.
pass  out  1  valid from done until next start: 1 if fail_mask==0.
fail_mask  out  6  sticky per-gate mismatch bits for current/last sweep.
first_fail_vld  out  1  set on first mismatch of a sweep.
first_fail_vec  out  2  {a,b} of first mismatching vector; valid when first_fail_vld.

Behaviour:
- Reset values (rst=1 at a clock edge, in any state):
  - state=IDLE; a=0, b=0; busy=0; done=0; pass=0.
  - fail_mask=0; first_fail_vld=0; first_fail_vec=0; vec=0; settle_cnt=0.
  - Reset mid-sweep aborts with no done pulse.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - vec<=0, {a,b}<=00, settle_cnt<=SETTLE_CYCLES-1.
  - fail_mask<=0, first_fail_vld<=0, pass<=0, busy<=1, state<=SETTLE.
- SETTLE:
  - If settle_cnt==0, state<=SAMPLE; otherwise decrement.
  - Total time spent in SETTLE per vector = SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - Compute expected vector E from {a,b}: E[0]=a&b, E[1]=a|b, E[2]=~a, E[3]=~(a&b), E[4]=~(a|b), E[5]=a^b.
  - mism = dut_y ^ E; fail_mask <= fail_mask | mism.
  - If mism!=0 and first_fail_vld==0: first_fail_vld<=1, first_fail_vec<=vec.
  - If vec==3, state<=DONE.
  - Otherwise vec<=vec+1, {a,b}<=vec+1 (a=MSB), settle_cnt reload, state<=SETTLE.
  - a/b change on the same edge that leaves SAMPLE.
- DONE (one cycle):
  - done=1, busy=0 registered on entry.
  - pass = (final fail_mask==0), using the mask including the last SAMPLE update.
  - state<=IDLE.
- Outputs after DONE:
  - a/b stay at 11 in IDLE until the next start.
  - pass, fail_mask and first_fail_* hold until the next accepted start.
- Latency: start sampled high at edge T gives done high in cycle T+1+4*(SETTLE_CYCLES+1); for SETTLE_CYCLES=2 that is T+13.
- start while busy or in DONE: ignored, no effect.
- start in the same cycle as rst: reset wins.
- vec is 2 bits and never wraps within a sweep; the terminal condition is vec==3.
- dut_y is sampled only in SAMPLE; glitches during SETTLE are don't-care.

Decomposition:
- Package gate_chk_pkg:
  - NUM_GATES=6.
  - Bit-index constants IDX_AND=0, IDX_OR=1, IDX_NOT=2, IDX_NAND=3, IDX_NOR=4, IDX_XOR=5.
  - State enum {IDLE, SETTLE, SAMPLE, DONE}.
- Sub-module gate_expect: purely combinational golden model, inputs a,b, output exp[5:0]. Reusable by other library checkers.
- FSM, counters and scoreboard live in gate_truth_checker.

Test Plan:
- Ideal gates wired to a/b, SETTLE_CYCLES=2, start pulse at T:
  - {a,b} sequence 00,01,10,11, each held 3 cycles.
  - done at T+13; pass=1, fail_mask=000000, first_fail_vld=0.
- XOR replaced by OR (dut_y[5]=a|b) -> mismatch only at vec=3; fail_mask=100000, first_fail_vld=1, first_fail_vec=11, pass=0.
- NOT output stuck at 0 -> first mismatch at vec=0; fail_mask=000100, first_fail_vec=00, pass=0.
- Reset mid-sweep:
  - Assert rst during SETTLE of vec=2 -> next cycle all outputs at reset values, no done pulse.
  - A new start then yields a clean sweep with done at T+13.
- start re-pulsed at T+5 during a sweep -> ignored; single done at T+13.
- Second start after a failing sweep -> fail_mask and first_fail_vld clear at T+1. With ideal gates: pass=1.
- SETTLE_CYCLES=1 -> each vector held 2 cycles; done at T+9.
